// File: rtl/seq_s_cla_ctrl.sv
// Sequential signed adder: one 4-bit CLA slice reused per nibble.
// Valid/ready on both sides; result held until accepted.
module seq_s_cla_ctrl #(
  parameter int N_NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4*N_NIBBLES-1:0]   a,
  input  logic [4*N_NIBBLES-1:0]   b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4*N_NIBBLES:0]     out,
  output logic                     out_ovf
);

  localparam int W  = 4 * N_NIBBLES;
  localparam int IW = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [W-1:0]    sum_r;
  logic [IW-1:0]   idx;
  logic            carry;

  logic [IW+1:0]   base;
  logic [3:0]      na;
  logic [3:0]      nb;
  logic [3:0]      p;
  logic [3:0]      g;
  logic [3:0]      s;
  logic [4:0]      c;
  logic [W-1:0]    sum_nxt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Shared CLA slice on the current nibble; c[3] is the carry into the top bit.
  always_comb begin
    base = {idx, 2'b00};
    na   = a_r[base +: 4];
    nb   = b_r[base +: 4];
    p    = na ^ nb;
    g    = na & nb;
    c[0] = carry;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s    = p ^ c[3:0];
    sum_nxt = sum_r;
    sum_nxt[base +: 4] = s;
  end

  // Control FSM plus datapath registers; out only updates on the last nibble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      idx     <= '0;
      carry   <= 1'b0;
      out     <= '0;
      out_ovf <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            idx   <= '0;
            carry <= 1'b0;
            state <= CALC;
          end
        end
        CALC: begin
          sum_r <= sum_nxt;
          carry <= c[4];
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            out     <= {a_r[W-1] ^ b_r[W-1] ^ c[4], sum_nxt};
            out_ovf <= c[3] ^ c[4];
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_s_cla_ctrl.sv
// Bench for seq_s_cla_ctrl: directed cases plus random
// back-to-back operations against an integer-arithmetic model.
module tb_seq_s_cla_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   out;
  logic         out_ovf;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W:0] last_out;
  logic       last_ovf;

  seq_s_cla_ctrl #(.N_NIBBLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] ref_sum(input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    int s;
    s = int'($signed(x)) + int'($signed(y));
    return (W+1)'(s);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x,
                                   input logic [W-1:0] y);
    int s;
    s = int'($signed(x)) + int'($signed(y));
    return (s > (2**(W-1)) - 1) || (s < -(2**(W-1)));
  endfunction

  // Called and returns at a negedge.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input int stall, input bit noisy);
    logic [W:0] e_out;
    logic       e_ovf;
    int lat;
    e_out = ref_sum(x, y);
    e_ovf = ref_ovf(x, y);
    a = x;
    b = y;
    in_valid = 1'b1;
    chk("in_ready_idle", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 3 * N + 4) begin
      chk("hold_calc", 32'(out), 32'(last_out));
      chk("in_ready_calc", 32'(in_ready), 0);
      if (noisy) begin
        in_valid  = 1'($urandom);
        a         = W'($urandom);
        b         = W'($urandom);
        out_ready = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    out_ready = 1'b0;
    chk("latency", 32'(lat), N);
    chk("sum", 32'(out), 32'(e_out));
    chk("ovf", 32'(out_ovf), 32'(e_ovf));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
      chk("stall_out", 32'(out), 32'(e_out));
      chk("stall_ovf", 32'(out_ovf), 32'(e_ovf));
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    in_valid  = noisy;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("xfer_valid", 32'(out_valid), 0);
    chk("xfer_ready", 32'(in_ready), 1);
    chk("idle_hold", 32'(out), 32'(e_out));
    last_out = e_out;
    last_ovf = e_ovf;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst = 1'b1;
    in_valid = 1'b1;
    a = 16'h1111;
    b = 16'h2222;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out", 32'(out), 0);
    chk("rst_ovf", 32'(out_ovf), 0);
    last_out = '0;
    last_ovf = 1'b0;

    run_op(16'h1234, 16'h4321, 0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 0, 1'b0);
    run_op(16'h8000, 16'h8000, 1, 1'b0);
    run_op(16'hFFFF, 16'h0001, 0, 1'b0);
    run_op(16'h0005, 16'hFFF0, 3, 1'b1);

    // Reset on the second CALC edge discards the operation.
    a = 16'h7000;
    b = 16'h7000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", 32'(in_ready), 1);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_out", 32'(out), 0);
    last_out = '0;
    repeat (N + 2) begin
      @(negedge clk);
      chk("mid_rst_no_pulse", 32'(out_valid), 0);
    end
    run_op(16'h0003, 16'hFFFE, 0, 1'b0);

    // Reset together with in_valid must not capture.
    rst = 1'b1;
    in_valid = 1'b1;
    a = 16'h0101;
    b = 16'h0202;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    last_out = '0;
    repeat (N + 2) begin
      @(negedge clk);
      chk("rst_cap_ready", 32'(in_ready), 1);
      chk("rst_cap_valid", 32'(out_valid), 0);
    end

    for (int k = 0; k < 60; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (k % 4 == 0) ra = {1'b0, {(W-1){1'b1}}} ^ W'($urandom_range(0, 3));
      if (k % 4 == 1) rb = {1'b1, {(W-1){1'b0}}} | W'($urandom_range(0, 3));
      run_op(ra, rb, int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_s_cla_ctrl.md
SEQ_S_CLA_CTRL -- requirements
Module: seq_s_cla_ctrl

Interface
REQ-001 The block SHALL have parameter N_NIBBLES, default 4, giving the number of 4-bit slices per operand; operand width W = 4*N_NIBBLES.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operand pair a/b is presented.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 a  input  W  signed two's-complement operand A.
REQ-008 b  input  W  signed two's-complement operand B.
REQ-009 out_valid  output  1  result on out/out_ovf is valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out  output  W+1  signed sum a+b, sign-extended to W+1 bits.
REQ-012 out_ovf  output  1  sum overflowed W-bit signed range.

Function
REQ-013 The block SHALL contain exactly one 4-bit signed-capable CLA slice (propagate/generate per bit, lookahead carries, carry-in), reused once per nibble.
REQ-014 The FSM SHALL have states IDLE, CALC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 IDLE: on an edge with in_valid=1, the block SHALL register a and b, clear the carry register and nibble index, and go to CALC; with in_valid=0 it SHALL stay in IDLE.
REQ-016 CALC: each edge SHALL add nibble[idx] of A and B plus the carry register, write the 4-bit sum into result bits [4*idx+3:4*idx], store the slice carry-out, and increment idx.
REQ-017 On the CALC edge with idx = N_NIBBLES-1, the block SHALL also compute out[W] = a[W-1] XOR b[W-1] XOR c_out and out_ovf = c_in(bit W-1) XOR c_out, then go to DONE.
REQ-018 Latency SHALL be exactly N_NIBBLES cycles from the accepting edge to out_valid=1 (4 for default), independent of operand values.
REQ-019 DONE: out and out_ovf SHALL hold stable while out_valid=1 and out_ready=0; on an edge with out_ready=1, the FSM SHALL go to IDLE.
REQ-020 The block SHALL not accept new operands in the DONE-to-IDLE transfer cycle; back-to-back throughput is one result per N_NIBBLES+2 cycles.
REQ-021 Changes on a/b/in_valid while in CALC or DONE SHALL have no effect on the result.
REQ-022 out_ready asserted outside DONE SHALL be ignored.
REQ-023 out and out_ovf SHALL hold their last values in IDLE and CALC; only out_valid qualifies them.

Reset
REQ-024 With rst=1 on an edge, the block SHALL enter IDLE, clear idx, carry, out, out_ovf and the operand registers; after reset in_ready=1 and out_valid=0.
REQ-025 Reset SHALL take priority over every handshake, including in CALC or DONE; the in-flight operation is discarded and no out_valid pulse is produced for it.
REQ-026 With rst=1 and in_valid=1 on the same edge, the block SHALL not capture the operands.

Verification
REQ-027 a=0x1234, b=0x4321 -> out=0x05555, out_ovf=0, out_valid exactly 4 cycles after acceptance.
REQ-028 a=0x7FFF, b=0x0001 -> out=0x08000, out_ovf=1; a=0x8000, b=0x8000 -> out=0x10000, out_ovf=1.
REQ-029 a=0xFFFF, b=0x0001 -> out=0x00000, out_ovf=0, which checks carry ripple through all four nibbles.
REQ-030 Result held with out_ready=0 for 3 cycles, with a/b/in_valid toggled meanwhile -> out stays constant, in_ready stays 0, one transfer when out_ready=1, then in_ready=1.
REQ-031 rst=1 asserted on the 2nd CALC edge -> the next cycle shows in_ready=1, out_valid=0, out=0; a following operation 0x0003+0xFFFE -> out=0x00001.
REQ-032 Randomized back-to-back operations with random out_ready stalls, compared against a reference signed W+1-bit sum and overflow model.
